ysyx_23060077_div_ctrl: RTL
===========================

// Module: ysyx_23060077_div_ctrl
// PURPOSE
//  Sequencer between the EXU and the iterative divider for RV32M DIV/DIVU/REM/REMU.
//  - Resolves divide-by-zero and signed overflow itself, without launching the divider.
//  - Keeps a one-entry result cache, so a DIV/REM pair on the same operands costs one divide.
//  - Owns flush: an in-flight divide is drained and its result discarded.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width (must equal `DATA_WIDTH)
//  TAG_WIDTH    5  destination tag carried from request to response
//  CACHE_EN     1  1 = result cache enabled; 0 = every non-special op launches the divider
// PORTS
//  clock       in   1    single clock, rising edge
//  reset       in   1    asynchronous, active-low; all state cleared while low
//  flush       in   1    pipeline flush
//  req_valid   in   1    op request
//  req_ready   out  1    controller can accept
//  req_op      in   2    00 DIV, 01 DIVU, 10 REM, 11 REMU
//  req_rs1     in   DW   dividend
//  req_rs2     in   DW   divisor
//  req_tag     in   TW   destination tag
//  res_valid   out  1    result available
//  res_ready   in   1    consumer takes result
//  res_data    out  DW   quotient (DIV*) or remainder (REM*)
//  res_tag     out  TW   tag of the accepted request
//  dv_valid    out  1    start pulse to divider (div_valid)
//  dv_ready    in   1    divider idle (div_ready)
//  dv_signed   out  1    = ~req_op[0] of the held op
//  dv_dividend out  DW   held rs1
//  dv_divisor  out  DW   held rs2
//  dv_flush    out  1    flush forwarded to divider
//  dv_out_valid in  1    divider one-cycle done pulse
//  dv_quotient in   DW   divider quotient
//  dv_remainder in  DW   divider remainder
// BEHAVIOUR
//  Reset values: req_ready=0, res_valid=0, res_data=0, res_tag=0, dv_valid=0, dv_flush=0; cache invalid.
//  States:
//  - IDLE:   req_ready = ~flush. On req_valid & req_ready, latch op/rs1/rs2/tag, then:
//            divisor==0: result is q=all-ones, r=rs1 -> RESP.
//            signed op & rs1==0x8000_0000 & rs2==all-ones: result is q=0x8000_0000, r=0 -> RESP.
//            cache hit (CACHE_EN, valid, equal rs1, rs2, signedness): cached q or r -> RESP.
//            otherwise -> LAUNCH.
//  - LAUNCH: dv_valid=1 while waiting for dv_ready; the divider samples in the cycle dv_valid & dv_ready.
//            Operands stay held. Next state is BUSY.
//  - BUSY:   wait for dv_out_valid; capture q/r into the cache (mark valid), select output -> RESP.
//  - RESP:   res_valid=1; res_data and res_tag stay stable until res_ready, then -> IDLE.
//            res_valid&res_ready and a new req in the same cycle: new req not accepted (req_ready=0 in RESP).
//  - DRAIN:  entered on flush in LAUNCH (after handshake) or in BUSY. Wait for dv_out_valid, discard the
//            result, do not update the cache -> IDLE.
//  Flush handling:
//  - flush in LAUNCH before the handshake: drop dv_valid -> IDLE.
//  - flush in RESP: drop the result -> IDLE.
//  - flush in IDLE: no accept.
//  - dv_flush = flush, registered for 1 cycle.
//  - flush and dv_out_valid in the same BUSY cycle: the result is discarded -> IDLE.
//  Latency (accept cycle = cycle 0):
//  - special case or cache hit: res_valid at cycle 1.
//  - divider path: res_valid 1 cycle after dv_out_valid.
//  Cache:
//  - One entry: rs1, rs2, signed, q, r.
//  - Invalidated only by reset. A special-case op never writes it.
//  Arithmetic: the divider returns signed q/r per RISC-V (remainder takes the dividend's sign).
//  No width extension is performed here.
// TESTING
//  1 DIV 100/7 -> dv_valid once, res_data=14; then REM 100/7 -> no dv_valid, res_data=2 at cycle 1
//  2 DIV 0xFFFF_FFF9/2 -> 0xFFFF_FFFD; REM -> 0xFFFF_FFFF; DIVU same -> divider relaunched, 0x7FFF_FFFC
//  3 DIVU 5/0 -> 0xFFFF_FFFF, REM 5/0 -> 5; DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000, REM -> 0, no dv_valid
//  4 flush 10 cycles into BUSY -> DRAIN, no res_valid, next DIV 9/3 -> 3 with divider relaunched (cache not updated)
//  5 res_ready held low 5 cycles -> res_valid/res_data/res_tag stable; req_ready=0 throughout
//  6 reset low mid-BUSY -> all outputs 0 immediately; after release, REM 100/7 misses cache -> dv_valid

Source files
------------

// File: rtl/ysyx_23060077_div_ctrl.sv
// ============================================================================
//  Module  : ysyx_23060077_div_ctrl
//  Brief   : RV32M DIV/DIVU/REM/REMU sequencer in front of an iterative divider.
//            Resolves divide-by-zero and signed overflow locally and keeps a
//            one-entry result cache so a DIV/REM pair costs a single divide.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_23060077_div_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter bit CACHE_EN   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_rs1,
    input  logic [DATA_WIDTH-1:0] req_rs2,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [TAG_WIDTH-1:0]  res_tag,
    output logic                  dv_valid,
    input  logic                  dv_ready,
    output logic                  dv_signed,
    output logic [DATA_WIDTH-1:0] dv_dividend,
    output logic [DATA_WIDTH-1:0] dv_divisor,
    output logic                  dv_flush,
    input  logic                  dv_out_valid,
    input  logic [DATA_WIDTH-1:0] dv_quotient,
    input  logic [DATA_WIDTH-1:0] dv_remainder
);

    localparam logic [DATA_WIDTH-1:0] C_ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] C_INT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_BUSY   = 3'd2,
        S_RESP   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  alive_q, alive_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] rs1_q, rs1_d;
    logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  dv_flush_q, dv_flush_d;

    logic                  w_accept;
    logic                  w_div_zero;
    logic                  w_overflow;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_hit_quo;
    logic [DATA_WIDTH-1:0] w_hit_rem;
    logic                  w_cache_we;

    assign w_accept   = req_valid & req_ready;
    assign w_div_zero = (req_rs2 == '0);
    assign w_overflow = ~req_op[0] & (req_rs1 == C_INT_MIN) & (req_rs2 == C_ALL_ONES);
    // A result raced by a flush is dropped, so it must not pollute the cache either.
    assign w_cache_we = (state_q == S_BUSY) & dv_out_valid & ~flush;

    generate
        if (CACHE_EN) begin : g_cache
            logic                  cache_vld_q, cache_vld_d;
            logic                  cache_sgn_q, cache_sgn_d;
            logic [DATA_WIDTH-1:0] cache_rs1_q, cache_rs1_d;
            logic [DATA_WIDTH-1:0] cache_rs2_q, cache_rs2_d;
            logic [DATA_WIDTH-1:0] cache_quo_q, cache_quo_d;
            logic [DATA_WIDTH-1:0] cache_rem_q, cache_rem_d;

            always_comb begin
                cache_vld_d = cache_vld_q;
                cache_sgn_d = cache_sgn_q;
                cache_rs1_d = cache_rs1_q;
                cache_rs2_d = cache_rs2_q;
                cache_quo_d = cache_quo_q;
                cache_rem_d = cache_rem_q;
                if (w_cache_we) begin
                    cache_vld_d = 1'b1;
                    cache_sgn_d = ~op_q[0];
                    cache_rs1_d = rs1_q;
                    cache_rs2_d = rs2_q;
                    cache_quo_d = dv_quotient;
                    cache_rem_d = dv_remainder;
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    cache_vld_q <= 1'b0;
                    cache_sgn_q <= 1'b0;
                    cache_rs1_q <= '0;
                    cache_rs2_q <= '0;
                    cache_quo_q <= '0;
                    cache_rem_q <= '0;
                end else begin
                    cache_vld_q <= cache_vld_d;
                    cache_sgn_q <= cache_sgn_d;
                    cache_rs1_q <= cache_rs1_d;
                    cache_rs2_q <= cache_rs2_d;
                    cache_quo_q <= cache_quo_d;
                    cache_rem_q <= cache_rem_d;
                end
            end

            assign w_hit     = cache_vld_q & (req_rs1 == cache_rs1_q) &
                               (req_rs2 == cache_rs2_q) & (~req_op[0] == cache_sgn_q);
            assign w_hit_quo = cache_quo_q;
            assign w_hit_rem = cache_rem_q;
        end else begin : g_no_cache
            assign w_hit     = 1'b0;
            assign w_hit_quo = '0;
            assign w_hit_rem = '0;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        alive_d    = 1'b1;
        op_d       = op_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        tag_d      = tag_q;
        res_data_d = res_data_q;
        dv_flush_d = flush;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d  = req_op;
                    rs1_d = req_rs1;
                    rs2_d = req_rs2;
                    tag_d = req_tag;
                    if (w_div_zero) begin
                        res_data_d = req_op[1] ? req_rs1 : C_ALL_ONES;
                        state_d    = S_RESP;
                    end else if (w_overflow) begin
                        res_data_d = req_op[1] ? '0 : C_INT_MIN;
                        state_d    = S_RESP;
                    end else if (w_hit) begin
                        res_data_d = req_op[1] ? w_hit_rem : w_hit_quo;
                        state_d    = S_RESP;
                    end else begin
                        state_d    = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                // Once the divider has sampled, it must be drained even when flushed.
                if (dv_ready) begin
                    state_d = flush ? S_DRAIN : S_BUSY;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = dv_out_valid ? S_IDLE : S_DRAIN;
                end else if (dv_out_valid) begin
                    res_data_d = op_q[1] ? dv_remainder : dv_quotient;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (flush || res_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (dv_out_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            alive_q    <= 1'b0;
            op_q       <= 2'b01;
            rs1_q      <= '0;
            rs2_q      <= '0;
            tag_q      <= '0;
            res_data_q <= '0;
            dv_flush_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            alive_q    <= alive_d;
            op_q       <= op_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            tag_q      <= tag_d;
            res_data_q <= res_data_d;
            dv_flush_q <= dv_flush_d;
        end
    end

    // alive_q keeps req_ready low while reset is asserted and for one cycle after.
    assign req_ready   = alive_q & (state_q == S_IDLE) & ~flush;
    assign res_valid   = (state_q == S_RESP) & ~flush;
    assign res_data    = res_data_q;
    assign res_tag     = tag_q;
    assign dv_valid    = (state_q == S_LAUNCH);
    assign dv_signed   = ~op_q[0];
    assign dv_dividend = rs1_q;
    assign dv_divisor  = rs2_q;
    assign dv_flush    = dv_flush_q;

endmodule

`default_nettype wire
